spi_flash_responder: RTL and testbench
======================================

# spi_flash_responder

SPI mode-0 flash responder that answers the `flashClk`/`flashMosi`/`flashCs`/`flashMiso` interface driven by the design's SPI flash master. It runs entirely on the system clock and oversamples the SPI pins. It serves READ (0x03) and JEDEC ID (0x9F) from a byte-wide synchronous read port. It is used as the flash model in system simulation and as a loopback target on the Tang Nano 9K.

## Interface

Parameters:
- `ADDR_W`, 24: width of `mem_addr`. The low `ADDR_W` bits of the 24-bit SPI address are used.
- `JEDEC_ID`, 24'hEF4016: ID bytes returned by 0x9F, MSB byte first.

Ports:
- `CLK`  in  1  system clock; the only clock.
- `RST`  in  1  synchronous, active-high reset.
- `flashClk`  in  1  SPI clock from the master; asynchronous.
- `flashCs`  in  1  SPI chip select, active low; asynchronous.
- `flashMosi`  in  1  master-to-responder data; asynchronous.
- `flashMiso`  out  1  responder-to-master data.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rd`  out  1  one-cycle read strobe.
- `mem_rdata`  in  8  read data, valid the cycle after `mem_rd`.
- `busy`  out  1  high while a transaction is in progress (CS asserted).
- `cmd_error`  out  1  one-cycle pulse when an unsupported opcode is received.

## Operation

Input conditioning:
- `flashClk`, `flashCs` and `flashMosi` each pass through a 2-flop synchronizer.
- Synchronizer reset values: CS = 1, SCK = 0, MOSI = 0.
- A third register on SCK and CS gives one-cycle rise/fall strobes.
- MOSI is sampled on a detected SCK rise. `flashMiso` is updated on a detected SCK fall. Bits are MSB first.

States: IDLE, CMD, ADDR, DATA, ID, IGNORE. A 3-bit bit counter counts bits within a byte.

Transitions:
- IDLE → CMD on CS fall. Bit counter is cleared and `busy` goes to 1.
- CMD, after 8 bits:
  - opcode 0x03 → ADDR.
  - opcode 0x9F → ID; shift register is loaded with `JEDEC_ID[23:16]`.
  - any other opcode → IGNORE; `cmd_error` pulses for 1 cycle.
- ADDR: 24 bits shifted into the address register. On the rise that samples bit 24:
  - `mem_rd` is asserted with `mem_addr` = address[ADDR_W-1:0].
  - Next cycle, `mem_rdata` is loaded into the output shift register.
  - Next state is DATA.
- DATA:
  - Each SCK fall shifts the next bit out.
  - On the rise that completes a byte's 8th bit, the address increments and `mem_rd` fires for the next byte, which is loaded before the following fall.
  - Address wraps modulo 2^ADDR_W.
  - MOSI is ignored.
- ID: outputs the 3 `JEDEC_ID` bytes, then 0x00 indefinitely.
- IGNORE: `flashMiso` = 0 until CS rises.
- Any state, on CS rise → IDLE:
  - `busy` = 0 and `flashMiso` = 0.
  - Partial bytes are discarded; no `mem_rd` is issued.
- CS fall and SCK edge in the same cycle: the CS fall is processed first. The SCK edge is ignored; this is legal in mode 0 only with SCK idle low.
- `flashMiso` is 0 in IDLE, CMD, ADDR and IGNORE.

## Timing

- Reset values: `flashMiso` = 0, `mem_rd` = 0, `mem_addr` = 0, `busy` = 0, `cmd_error` = 0, state = IDLE.
- RST asserted mid-transaction returns to IDLE in 1 cycle. The responder then waits for a fresh CS fall; a CS still low after reset is not treated as a new transaction.
- Pin-to-strobe latency is 3 CLK cycles. `flashMiso` changes 4 CLK cycles after the SCK fall at the pin.
- SCK high and low times must each be at least 6 CLK cycles. CS setup/hold around SCK edges must be at least 4 CLK cycles.
- Memory fetch: `mem_rd` fires 1 cycle after the rise strobe. Data is captured 2 cycles after the rise strobe, well before the next fall strobe.
- `mem_rd` fires once per data byte. A byte is prefetched even if CS rises before it is clocked out.
- `busy` rises 1 cycle after the CS fall strobe and falls 1 cycle after the CS rise strobe.

## Test plan

- Reset, then hold CS high and toggle SCK 16 times → `flashMiso` = 0, `busy` = 0, `mem_rd` never asserted.
- CS low, send 0x9F, clock 32 bits → master receives 0xEF, 0x40, 0x16, 0x00; no `mem_rd`.
- Memory holds byte = addr+1. Send 0x03 0x00 0x00 0x10, clock 4 bytes → receive 0x11, 0x12, 0x13, 0x14; `mem_addr` sequence 0x10, 0x11, 0x12, 0x13, 0x14.
- ADDR_W = 8, READ at 0x0000FE, clock 3 bytes → `mem_addr` 0xFE, 0xFF, 0x00; data 0xFF, 0x00, 0x01.
- Raise CS after 12 address bits, then run a full JEDEC transaction → state returns to IDLE and the ID reads correctly.
- Send opcode 0xAB, clock 16 more bits → `cmd_error` pulses once, `flashMiso` stays 0, `busy` = 0 after CS rises.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder serving READ (0x03) and JEDEC ID (0x9F), oversampling the SPI pins on CLK.
// Pin edges reach strobes after 3 CLK and MISO moves 4 CLK after an SCK fall; the master paces everything, so there is no backpressure.
module spi_flash_responder #(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flashClk,
    input  logic              flashCs,
    input  logic              flashMosi,
    output logic              flashMiso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_ID,
        S_IGNORE
    } state_t;

    state_t      r_state;
    logic        r_sck_s1, r_sck_s2, r_sck_s3;
    logic        r_cs_s1, r_cs_s2, r_cs_s3;
    logic        r_mosi_s1, r_mosi_s2, r_mosi_d;
    logic        r_sck_rise, r_sck_fall, r_cs_rise, r_cs_fall;
    logic [1:0]  r_settle;
    logic        r_cs_armed;
    logic [2:0]  r_bit_cnt;
    logic [1:0]  r_byte_cnt;
    logic [1:0]  r_id_idx;
    logic [6:0]  r_cmd_sr;
    logic [22:0] r_addr;
    logic [7:0]  r_shift;
    logic        r_load;

    logic [7:0]  w_cmd_next;
    logic [23:0] w_addr_next;
    logic        w_byte_end;

    assign w_cmd_next  = {r_cmd_sr, r_mosi_d};
    assign w_addr_next = {r_addr, r_mosi_d};
    assign w_byte_end  = r_sck_rise && (r_bit_cnt == 3'd7);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_sck_s1   <= 1'b0;
            r_sck_s2   <= 1'b0;
            r_sck_s3   <= 1'b0;
            r_cs_s1    <= 1'b1;
            r_cs_s2    <= 1'b1;
            r_cs_s3    <= 1'b1;
            r_mosi_s1  <= 1'b0;
            r_mosi_s2  <= 1'b0;
            r_mosi_d   <= 1'b0;
            r_sck_rise <= 1'b0;
            r_sck_fall <= 1'b0;
            r_cs_rise  <= 1'b0;
            r_cs_fall  <= 1'b0;
            r_settle   <= 2'd0;
            r_cs_armed <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 2'd0;
            r_id_idx   <= 2'd0;
            r_cmd_sr   <= 7'd0;
            r_addr     <= 23'd0;
            r_shift    <= 8'd0;
            r_load     <= 1'b0;
            flashMiso  <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            busy       <= 1'b0;
            cmd_error  <= 1'b0;
        end else begin
            r_sck_s1  <= flashClk;
            r_sck_s2  <= r_sck_s1;
            r_sck_s3  <= r_sck_s2;
            r_cs_s1   <= flashCs;
            r_cs_s2   <= r_cs_s1;
            r_cs_s3   <= r_cs_s2;
            r_mosi_s1 <= flashMosi;
            r_mosi_s2 <= r_mosi_s1;
            r_mosi_d  <= r_mosi_s2;

            r_sck_rise <= r_sck_s2 & ~r_sck_s3;
            r_sck_fall <= ~r_sck_s2 & r_sck_s3;
            r_cs_rise  <= r_cs_s2 & ~r_cs_s3;
            r_cs_fall  <= ~r_cs_s2 & r_cs_s3 & r_cs_armed;

            // A CS already low when reset releases must be seen high before a fall counts
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end else if (r_cs_s3) begin
                r_cs_armed <= 1'b1;
            end

            mem_rd    <= 1'b0;
            cmd_error <= 1'b0;
            r_load    <= mem_rd;
            if (r_load) begin
                r_shift <= mem_rdata;
            end

            if (r_cs_rise) begin
                r_state   <= S_IDLE;
                busy      <= 1'b0;
                flashMiso <= 1'b0;
            end else if (r_cs_fall && (r_state == S_IDLE)) begin
                r_state   <= S_CMD;
                r_bit_cnt <= 3'd0;
                busy      <= 1'b1;
                flashMiso <= 1'b0;
            end else if (r_state != S_IDLE) begin
                if (r_sck_rise) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                case (r_state)
                    S_CMD: begin
                        if (r_sck_rise) begin
                            r_cmd_sr <= w_cmd_next[6:0];
                        end
                        if (w_byte_end) begin
                            if (w_cmd_next == 8'h03) begin
                                r_state    <= S_ADDR;
                                r_byte_cnt <= 2'd0;
                            end else if (w_cmd_next == 8'h9F) begin
                                r_state  <= S_ID;
                                r_shift  <= JEDEC_ID[23:16];
                                r_id_idx <= 2'd1;
                            end else begin
                                r_state   <= S_IGNORE;
                                cmd_error <= 1'b1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (r_sck_rise) begin
                            r_addr <= w_addr_next[22:0];
                        end
                        if (w_byte_end) begin
                            if (r_byte_cnt == 2'd2) begin
                                mem_rd   <= 1'b1;
                                mem_addr <= w_addr_next[ADDR_W-1:0];
                                r_state  <= S_DATA;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 2'd1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (r_sck_fall) begin
                            flashMiso <= r_shift[7];
                            r_shift   <= {r_shift[6:0], 1'b0};
                        end
                        // Prefetch the next byte so it is loaded before the following fall
                        if (w_byte_end) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end
                    S_ID: begin
                        if (r_sck_fall) begin
                            flashMiso <= r_shift[7];
                            r_shift   <= {r_shift[6:0], 1'b0};
                        end
                        if (w_byte_end) begin
                            case (r_id_idx)
                                2'd1:    r_shift <= JEDEC_ID[15:8];
                                2'd2:    r_shift <= JEDEC_ID[7:0];
                                default: r_shift <= 8'h00;
                            endcase
                            if (r_id_idx != 2'd3) begin
                                r_id_idx <= r_id_idx + 2'd1;
                            end
                        end
                    end
                    S_IGNORE: begin
                        flashMiso <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: a 24-bit and an 8-bit address instance share the SPI pins.
module tb_spi_flash_responder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        sck, cs, mosi;
    logic        miso24, miso8;
    logic [23:0] addr24;
    logic [7:0]  addr8;
    logic        rd24, rd8;
    logic [7:0]  rdata24, rdata8;
    logic        busy24, busy8, err24, err8;

    always #5 CLK = ~CLK;

    spi_flash_responder #(.ADDR_W(24)) dut24 (
        .CLK(CLK), .RST(RST), .flashClk(sck), .flashCs(cs), .flashMosi(mosi),
        .flashMiso(miso24), .mem_addr(addr24), .mem_rd(rd24), .mem_rdata(rdata24),
        .busy(busy24), .cmd_error(err24)
    );

    spi_flash_responder #(.ADDR_W(8)) dut8 (
        .CLK(CLK), .RST(RST), .flashClk(sck), .flashCs(cs), .flashMosi(mosi),
        .flashMiso(miso8), .mem_addr(addr8), .mem_rd(rd8), .mem_rdata(rdata8),
        .busy(busy8), .cmd_error(err8)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mem_key = 8'd0;
    logic [7:0]  rx24_q[$];
    logic [7:0]  rx8_q[$];
    logic [23:0] rd24_q[$];
    logic [7:0]  rd8_q[$];
    int          err24_cnt = 0;
    int          err8_cnt = 0;
    logic [7:0]  rxb24, rxb8;

    // Flash contents: a fixed function of the address, shifted by a per-test key
    function automatic logic [7:0] mem_val(input logic [23:0] a);
        return a[7:0] + (a[15:8] << 1) + a[15:8] + a[23:16] + mem_key;
    endfunction

    always @(posedge CLK) begin
        if (rd24) begin
            rdata24 <= mem_val(addr24);
            rd24_q.push_back(addr24);
        end
        if (rd8) begin
            rdata8 <= mem_val({16'd0, addr8});
            rd8_q.push_back(addr8);
        end
        if (err24) err24_cnt++;
        if (err8) err8_cnt++;
    end

    // Byte seen by the master at position pos of a transaction (pos 0 is the opcode slot)
    function automatic logic [7:0] exp_byte(input logic [7:0] op, input logic [23:0] a,
                                            input int pos, input int w);
        logic [23:0] mask;
        logic [23:0] id;
        mask = (w == 24) ? 24'hFFFFFF : 24'h0000FF;
        id   = 24'hEF4016;
        if (op == 8'h03 && pos >= 4) return mem_val((a + 24'(pos - 4)) & mask);
        if (op == 8'h9F && pos >= 1 && pos <= 3) return id[8*(3-pos) +: 8];
        return 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb);
        for (int i = 0; i < nb; i++) begin
            mosi = tx[7-i];
            repeat (8) @(negedge CLK);
            sck   = 1'b1;
            rxb24 = {rxb24[6:0], miso24};
            rxb8  = {rxb8[6:0], miso8};
            repeat (8) @(negedge CLK);
            sck = 1'b0;
        end
    endtask

    task automatic tx_byte(input logic [7:0] tx);
        spi_bits(tx, 8);
        rx24_q.push_back(rxb24);
        rx8_q.push_back(rxb8);
    endtask

    task automatic cs_low();
        @(negedge CLK);
        cs = 1'b0;
        repeat (8) @(negedge CLK);
    endtask

    task automatic cs_high();
        repeat (8) @(negedge CLK);
        cs = 1'b1;
        repeat (10) @(negedge CLK);
    endtask

    task automatic clear_logs();
        rx24_q.delete();
        rx8_q.delete();
        rd24_q.delete();
        rd8_q.delete();
        err24_cnt = 0;
        err8_cnt  = 0;
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [23:0] a, input int n);
        int nr;
        clear_logs();
        cs_low();
        check("busy_on", {31'd0, busy24}, 32'd1);
        tx_byte(op);
        if (op == 8'h03) begin
            tx_byte(a[23:16]);
            tx_byte(a[15:8]);
            tx_byte(a[7:0]);
        end
        for (int i = 0; i < n; i++) tx_byte(8'($urandom));
        cs_high();
        check("busy_off", {31'd0, busy24}, 32'd0);
        check("busy8_off", {31'd0, busy8}, 32'd0);
        for (int p = 0; p < rx24_q.size(); p++) begin
            check("miso24_byte", {24'd0, rx24_q[p]}, {24'd0, exp_byte(op, a, p, 24)});
            check("miso8_byte", {24'd0, rx8_q[p]}, {24'd0, exp_byte(op, a, p, 8)});
        end
        nr = (op == 8'h03) ? n + 1 : 0;
        check("rd24_count", rd24_q.size(), nr);
        check("rd8_count", rd8_q.size(), nr);
        for (int k = 0; k < nr; k++) begin
            if (k < rd24_q.size())
                check("rd24_addr", {8'd0, rd24_q[k]}, {8'd0, a + 24'(k)});
            if (k < rd8_q.size())
                check("rd8_addr", {24'd0, rd8_q[k]}, {24'd0, a[7:0] + 8'(k)});
        end
        check("cmd_error24", err24_cnt, (op != 8'h03 && op != 8'h9F) ? 1 : 0);
        check("cmd_error8", err8_cnt, (op != 8'h03 && op != 8'h9F) ? 1 : 0);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        int          n;
        logic [7:0]  key;
        logic        use8;
        logic [31:0] exp;
        int          exp_err;
    } vec_t;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   off;
        logic [7:0] got;
        logic [7:0] op;
        logic [23:0] a;

        tbl[0] = '{op: 8'h9F, addr: 24'h0,  n: 4, key: 8'h00, use8: 1'b0, exp: 32'hEF401600, exp_err: 0};
        tbl[1] = '{op: 8'h03, addr: 24'h10, n: 4, key: 8'h01, use8: 1'b0, exp: 32'h11121314, exp_err: 0};
        tbl[2] = '{op: 8'h03, addr: 24'hFE, n: 3, key: 8'h01, use8: 1'b1, exp: 32'hFF000100, exp_err: 0};
        tbl[3] = '{op: 8'hAB, addr: 24'h0,  n: 2, key: 8'h00, use8: 1'b0, exp: 32'h00000000, exp_err: 1};

        RST = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        rxb24 = 8'd0; rxb8 = 8'd0;
        repeat (4) @(negedge CLK);
        check("rst_miso", {31'd0, miso24}, 32'd0);
        check("rst_busy", {31'd0, busy24}, 32'd0);
        check("rst_mem_rd", {31'd0, rd24}, 32'd0);
        check("rst_cmd_error", {31'd0, err24}, 32'd0);
        check("rst_mem_addr", {8'd0, addr24}, 32'd0);
        RST = 1'b0;
        repeat (10) @(negedge CLK);

        // SCK toggling with CS high must be ignored
        clear_logs();
        spi_bits(8'hA5, 8);
        check("idle_miso_a", {24'd0, rxb24}, 32'd0);
        spi_bits(8'h3C, 8);
        check("idle_miso_b", {24'd0, rxb24}, 32'd0);
        check("idle_busy", {31'd0, busy24}, 32'd0);
        check("idle_rd", rd24_q.size(), 0);

        for (int t = 0; t < 4; t++) begin
            mem_key = tbl[t].key;
            run_txn(tbl[t].op, tbl[t].addr, tbl[t].n);
            off = (tbl[t].op == 8'h03) ? 4 : 1;
            for (int i = 0; i < tbl[t].n; i++) begin
                got = tbl[t].use8 ? rx8_q[off+i] : rx24_q[off+i];
                check("table_data", {24'd0, got}, {24'd0, tbl[t].exp[31-8*i -: 8]});
            end
            check("table_err", err24_cnt, tbl[t].exp_err);
        end

        // Abort mid-address, then a clean JEDEC read
        clear_logs();
        cs_low();
        spi_bits(8'h03, 8);
        spi_bits(8'h12, 8);
        spi_bits(8'h34, 4);
        cs_high();
        check("abort_busy", {31'd0, busy24}, 32'd0);
        check("abort_rd", rd24_q.size(), 0);
        run_txn(8'h9F, 24'h0, 4);

        // Reset mid-transaction with CS held low: no new transaction until CS cycles
        clear_logs();
        cs_low();
        spi_bits(8'h03, 8);
        spi_bits(8'h00, 8);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        spi_bits(8'h00, 8);
        spi_bits(8'h40, 8);
        check("rst_mid_busy", {31'd0, busy24}, 32'd0);
        check("rst_mid_miso", {24'd0, rxb24}, 32'd0);
        cs_high();
        check("rst_mid_rd", rd24_q.size(), 0);
        mem_key = 8'h5A;
        run_txn(8'h03, 24'h00ABCD, 2);

        for (int r = 0; r < 14; r++) begin
            case ($urandom_range(0, 3))
                0, 1:    op = 8'h03;
                2:       op = 8'h9F;
                default: op = 8'($urandom);
            endcase
            a       = 24'($urandom);
            mem_key = 8'($urandom);
            run_txn(op, a, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
